// File: rtl/argmax_scan.sv
// argmax_scan
//   Scans NUM_CLASSES signed scores from an external memory starting at
//   base_addr and reports the index and value of the largest score, the
//   index of the runner-up, and the (non-negative) margin between them.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       synchronous reset, active-low
//   start       one-cycle scan request, honoured only in IDLE
//   base_addr   address of class 0, captured with start
//   rd_data     signed score, RD_LAT cycles after its address
//   re          read enable to the score memory
//   rd_addr     read address (holds when re=0)
//   busy        high from the start-sampling edge until done
//   done        one-cycle pulse, results valid from this cycle
//   result_idx  index of the maximum score
//   result_max  maximum score
//   second_idx  index of the runner-up score
//   margin      result_max minus runner-up, DATA_W+1 bits
module argmax_scan #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 13,
    parameter int NUM_CLASSES = 11,
    parameter int RD_LAT      = 1,
    parameter int TIE_LAST    = 1,
    localparam int IDX_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              re,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  result_idx,
    output logic [DATA_W-1:0] result_max,
    output logic [IDX_W-1:0]  second_idx,
    output logic [DATA_W:0]   margin
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]         cnt;
    logic [RD_LAT-1:0]        vpipe;
    logic [IDX_W-1:0]         ipipe [RD_LAT];
    logic                     dvalid;
    logic [IDX_W-1:0]         didx;
    logic signed [DATA_W-1:0] d;
    logic                     last;

    // Working (running) values
    logic                     have_max, have_sec;
    logic signed [DATA_W-1:0] w_max, w_sec;
    logic [IDX_W-1:0]         w_idx, w_sidx;

    // Values after folding in the current score
    logic signed [DATA_W-1:0] n_max, n_sec;
    logic [IDX_W-1:0]         n_idx, n_sidx;
    logic                     n_hsec;
    logic [DATA_W:0]          n_margin;

    function automatic logic beats(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b);
        return (TIE_LAST != 0) ? (a >= b) : (a > b);
    endfunction

    assign dvalid = vpipe[RD_LAT-1];
    assign didx   = ipipe[RD_LAT-1];
    assign d      = signed'(rd_data);
    assign last   = dvalid && (didx == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start in the done cycle (already IDLE) is ignored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !done)      state_nxt = ISSUE;
            ISSUE:   if (cnt == LAST_IDX)     state_nxt = DRAIN;
            DRAIN:   if (last)                state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        re   = (state == ISSUE);
        busy = (state != IDLE);
    end

    // Fold the current score into the running max / runner-up
    always_comb begin
        n_max  = w_max;
        n_idx  = w_idx;
        n_sec  = w_sec;
        n_sidx = w_sidx;
        n_hsec = have_sec;
        if (!have_max) begin
            n_max = d;
            n_idx = didx;
        end else if (beats(d, w_max)) begin
            n_sec  = w_max;
            n_sidx = w_idx;
            n_hsec = 1'b1;
            n_max  = d;
            n_idx  = didx;
        end else if (!have_sec || beats(d, w_sec)) begin
            n_sec  = d;
            n_sidx = didx;
            n_hsec = 1'b1;
        end
        n_margin = {n_max[DATA_W-1], n_max} - {n_sec[DATA_W-1], n_sec};
    end

    // Address issue, valid/index pipeline, working and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            rd_addr    <= '0;
            vpipe      <= '0;
            for (int unsigned k = 0; k < RD_LAT; k++) ipipe[k] <= '0;
            have_max   <= 1'b0;
            have_sec   <= 1'b0;
            w_max      <= '0;
            w_sec      <= '0;
            w_idx      <= '0;
            w_sidx     <= '0;
            done       <= 1'b0;
            result_idx <= '0;
            result_max <= '0;
            second_idx <= '0;
            margin     <= '0;
        end else begin
            done     <= 1'b0;
            vpipe[0] <= (state == ISSUE);
            ipipe[0] <= cnt;
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                vpipe[k] <= vpipe[k-1];
                ipipe[k] <= ipipe[k-1];
            end

            case (state)
                IDLE: begin
                    if (start && !done) begin
                        rd_addr  <= base_addr;
                        cnt      <= '0;
                        have_max <= 1'b0;
                        have_sec <= 1'b0;
                    end
                end
                ISSUE: begin
                    // Stop advancing on the last address so rd_addr holds
                    if (cnt != LAST_IDX) begin
                        cnt     <= cnt + 1'b1;
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                default: ;
            endcase

            if (dvalid) begin
                have_max <= 1'b1;
                have_sec <= n_hsec;
                w_max    <= n_max;
                w_idx    <= n_idx;
                w_sec    <= n_sec;
                w_sidx   <= n_sidx;
            end

            if (last) begin
                done       <= 1'b1;
                result_idx <= n_idx;
                result_max <= n_max;
                second_idx <= n_sidx;
                margin     <= n_margin;
            end
        end
    end

endmodule

// File: doc/argmax_scan.md
ARGMAX_SCAN -- requirements
Module: argmax_scan

Interface
REQ-001 SHALL provide parameter DATA_W, default 16: width of each signed class score.
REQ-002 SHALL provide parameter ADDR_W, default 13: score memory address width.
REQ-003 SHALL provide parameter NUM_CLASSES, default 11: scores scanned per run; legal range 2..2^ADDR_W.
REQ-004 SHALL provide parameter RD_LAT, default 1: score memory read latency in cycles; legal values 1 or 2.
REQ-005 SHALL provide parameter TIE_LAST, default 1: 1 = a later equal score wins a tie, 0 = the earlier score wins.
REQ-006 SHALL provide localparam IDX_W = clog2(NUM_CLASSES), minimum 1.
REQ-007 clk  in  1  single clock; all logic on the rising edge.
REQ-008 rst_n  in  1  synchronous reset, active-low.
REQ-009 start  in  1  one-cycle request to scan; sampled only in IDLE.
REQ-010 base_addr  in  ADDR_W  address of class 0; sampled together with start.
REQ-011 rd_data  in  DATA_W  signed score returned RD_LAT cycles after the address is presented.
REQ-012 re  out  1  read enable to the score memory.
REQ-013 rd_addr  out  ADDR_W  read address.
REQ-014 busy  out  1  high from the start-sampling edge until done.
REQ-015 done  out  1  one-cycle pulse; results are valid from this cycle.
REQ-016 result_idx  out  IDX_W  index of the maximum score.
REQ-017 result_max  out  DATA_W  maximum score, signed.
REQ-018 second_idx  out  IDX_W  index of the runner-up score.
REQ-019 margin  out  DATA_W+1  result_max minus runner-up score, unsigned, never negative.

Function
REQ-020 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE with these transitions:
- IDLE -> ISSUE on start=1.
- ISSUE -> DRAIN after NUM_CLASSES addresses are issued.
- DRAIN -> IDLE when the last score is compared.
REQ-021 In ISSUE, SHALL hold re=1 and present rd_addr = base_addr+i for i = 0..NUM_CLASSES-1, one address per cycle, with no gaps.
REQ-022 rd_addr arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-023 re SHALL be 0 in IDLE and DRAIN; rd_addr SHALL hold its last value when re=0.
REQ-024 SHALL track score validity with an RD_LAT-deep valid/index pipeline so that the score for address i is paired with index i.
REQ-025 The first valid score SHALL initialise the running max unconditionally, so an all-negative score vector is handled correctly.
REQ-026 Each subsequent score SHALL be compared signed:
- Beats max (>, or >= when TIE_LAST=1): the old max becomes the runner-up and the new score becomes the max.
- Otherwise, beats runner-up (same tie rule): the new score becomes the runner-up.
- The runner-up is initialised by the second valid score if not set earlier.
REQ-027 margin SHALL be computed in DATA_W+1 bits with sign extension, so it does not overflow.
REQ-028 done SHALL rise for exactly one cycle, NUM_CLASSES+RD_LAT cycles after the start-sampling edge; busy SHALL fall in the same cycle done rises.
REQ-029 Running values SHALL live in working registers; the output registers SHALL update only in the done cycle and hold until the next done.
REQ-030 start asserted while busy=1 SHALL be ignored, with no queueing.
REQ-031 start in the same cycle as done SHALL be ignored; a new start is accepted from the following cycle.

Reset
REQ-032 When rst_n=0 at a rising edge, the FSM SHALL go to IDLE and SHALL set re=0, rd_addr=0, busy=0, done=0, result_idx=0, result_max=0, second_idx=0, margin=0.
REQ-033 Reset asserted mid-scan SHALL abort the scan; no done pulse SHALL be produced for the aborted run.
REQ-034 The first start after reset deassertion SHALL be accepted.

Verification
REQ-035 Verification SHALL cover these directed scenarios:
- NUM_CLASSES=11, RD_LAT=1, base=100, scores 0,5,3,9,2,9,1,0,4,7,8, TIE_LAST=1 -> result_idx=5, result_max=9, second_idx=3, margin=0, done 12 cycles after start, rd_addr 100..110.
- Same scores with TIE_LAST=0 -> result_idx=3, second_idx=5.
- All negative scores -5,-2,-9,-3, NUM_CLASSES=4 -> result_idx=1, result_max=-2, second_idx=3, margin=1.
- base=2^ADDR_W-2, NUM_CLASSES=4, RD_LAT=2 -> rd_addr sequence max-1, max, 0, 1; done 6 cycles after start.
- rst_n low at cycle 3 of a scan -> no done pulse, all outputs 0; the next start completes normally.
- start pulsed during busy and in the done cycle -> ignored; outputs stable until the next accepted run's done.
